dbram_bank_reader: RTL and testbench
====================================

Name: dbram_bank_reader

Overview:
Consumer-side controller for a ping-pong (double-buffered) 4096x60 dual-port RAM pair. The writer fills one bank and announces it. This block then streams the filled bank out through a valid/ready interface, while the writer fills the other bank. When a bank is fully drained, the block returns it to the writer. It sits between the bank-select memory wrapper's read port and downstream compute/stream logic.

Parameters:
AWIDTH, 12, word address width per bank
NUM_WORDS, 4096, words per bank
DWIDTH, 60, data word width
RD_LATENCY, 1, cycles from rd_en to rd_data valid (1..4)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fill_valid  input  1  one-cycle pulse: writer has completed a bank
fill_bank  input  1  bank index announced by fill_valid
fill_len  input  AWIDTH+1  words written into the bank, 0..NUM_WORDS
rd_en  output  1  memory read strobe
rd_bank  output  1  bank being read (drives bank-select mux)
rd_addr  output  AWIDTH  read word address
rd_data  input  DWIDTH  read data, valid RD_LATENCY cycles after rd_en
out_valid  output  1  stream word available
out_ready  input  1  downstream accepts word
out_data  output  DWIDTH  stream word
out_last  output  1  marks final word of a bank
release_valid  output  1  one-cycle pulse: bank returned to writer
release_bank  output  1  bank index released
overflow_err  output  1  sticky error flag

Behaviour:
- Reset: all outputs 0. Both bank full flags cleared, next_bank=0, FSM in IDLE, FIFO emptied, in-flight read pipeline discarded. Reset mid-bank abandons that bank without a release pulse.
- Per-bank state: full flag and stored length. A fill_valid on an empty bank sets that bank's flag and stores fill_len.
- fill_valid on a bank that is already full (including one whose release pulse is in the same cycle): fill is ignored and overflow_err is set until reset.
- fill_len > NUM_WORDS: clamp to NUM_WORDS and set overflow_err.
- Banks are consumed strictly in order 0,1,0,1… using next_bank.
- FSM:
  - IDLE -> READ when next_bank is full and len>0.
  - IDLE -> RELEASE when next_bank is full and len=0. No words are output.
  - READ: issue rd_en with rd_bank=next_bank and rd_addr 0..len-1, incrementing by 1 per issued read. After issuing address len-1, go to DRAIN.
  - DRAIN -> RELEASE when the last word has been handshaken out (out_valid&&out_ready&&out_last).
  - RELEASE: one-cycle state. release_valid=1 and release_bank=next_bank. Clear that bank's flag, toggle next_bank, go to IDLE.
- Read credit: internal output FIFO of depth RD_LATENCY+2. rd_en is asserted only when FIFO occupancy + in-flight reads < depth. The block never drops data.
- Returning rd_data is pushed into the FIFO. The word for address len-1 carries out_last=1.
- Timing (RD_LATENCY=1, out_ready=1): fill_valid on bank 0 at cycle 0 gives:
  - rd_en with addr 0 at cycle 1;
  - out_valid with word 0 at cycle 3;
  - then 1 word/cycle sustained.
- Back-pressure: out_data/out_last hold stable while out_valid && !out_ready.
- Address counter never wraps: max address is NUM_WORDS-1, reached only when len=NUM_WORDS.
- Other bank filled while reading: recorded; consumption starts in the cycle after RELEASE returns to IDLE.

Optional Feature:
Macro DBR_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits). It counts cycles with out_valid && !out_ready, saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Fill bank 0 with len=8 (data = address), out_ready=1 -> words 0..7 on consecutive cycles starting cycle 3; out_last on word 7; release_valid with release_bank=0 one cycle after last handshake.
- Fill bank 0 (len=4) and bank 1 (len=3) back-to-back -> 4 words from bank 0, release 0, then 3 words from bank 1, release 1. No reads from bank 1 before release 0.
- out_ready toggling 1010… with len=16 and RD_LATENCY=3 -> all 16 words in order, none lost or duplicated, FIFO never exceeds 5 entries, data stable during stalls.
- fill_valid on bank 0 with len=0 -> no out_valid; release_valid for bank 0 within 3 cycles.
- Second fill_valid on full bank 1 -> overflow_err=1, original length retained, stays 1 until reset.
- Assert reset mid-READ of a 4096-word bank -> all outputs 0 next cycle; a new fill of bank 0 (len=2) streams exactly 2 words. With DBR_STALL_CNT_EN, holding out_ready=0 for 10 cycles with out_valid=1 gives stall_cnt=10.

Source files
------------

// File: rtl/dbram_bank_reader.sv
// rtl/dbram_bank_reader.sv - consumer side of a ping-pong 4096x60 dual-port RAM pair
//
// Streams each filled bank out in order (0,1,0,1...) and hands the bank back
// to the writer once its last word has been accepted downstream.
//
// Optional feature: define DBR_STALL_CNT_EN to add the stall_cnt output.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   fill_valid/bank/len         writer announces a completed bank and its length
//   rd_en/rd_bank/rd_addr       read strobe, bank select and word address to the RAM
//   rd_data                     read data, valid RD_LATENCY cycles after rd_en
//   out_valid/ready/data/last   output word stream, out_last on a bank's final word
//   release_valid/bank          one-cycle pulse returning a drained bank
//   overflow_err                sticky: fill on a full bank or fill_len > NUM_WORDS
//   stall_cnt                   (DBR_STALL_CNT_EN only) saturating back-pressure cycle count

module dbram_bank_reader #(
    parameter int AWIDTH     = 12,
    parameter int NUM_WORDS  = 4096,
    parameter int DWIDTH     = 60,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_valid,
    input  logic              fill_bank,
    input  logic [AWIDTH:0]   fill_len,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              release_valid,
    output logic              release_bank,
    output logic              overflow_err
`ifdef DBR_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int DEPTH = RD_LATENCY + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LW    = AWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t state;
    logic   next_bank;

    // Per-bank bookkeeping
    logic [1:0]    bank_full;
    logic [LW-1:0] bank_len [2];

    // Read-return pipeline: valid and last-word marker per outstanding read
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [RD_LATENCY-1:0] pipe_last;

    // Output FIFO
    logic [DWIDTH-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_last;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;

    logic          fill_over;
    logic [LW-1:0] fill_len_c;
    logic          fill_accept;
    logic          cur_full;
    logic [LW-1:0] cur_len;
    logic          last_addr_hit;
    logic          push;
    logic          pop;
    logic [7:0]    inflight;
    logic          credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fill_over   = fill_len > LW'(NUM_WORDS);
    assign fill_len_c  = fill_over ? LW'(NUM_WORDS) : fill_len;
    assign fill_accept = fill_valid && !bank_full[fill_bank];

    // IDLE looks through an arriving fill for next_bank so the first read
    // issues in the cycle right after the announcement.
    assign cur_full = bank_full[next_bank] || (fill_accept && (fill_bank == next_bank));
    assign cur_len  = bank_full[next_bank] ? bank_len[next_bank] : fill_len_c;

    assign last_addr_hit = ({1'b0, rd_addr} == (bank_len[next_bank] - LW'(1)));

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last   = out_valid && fifo_last[rd_ptr];
    assign push       = pipe_vld[RD_LATENCY-1];
    assign pop        = out_valid && out_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // Credit for the read issued next cycle: FIFO occupancy after this edge plus
    // every read still in flight after this edge must leave one free slot.
    always_comb begin
        inflight = 8'(rd_en);
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            inflight = inflight + 8'(pipe_vld[i]);
        end
        credit_ok = (8'(count_next) + inflight) < 8'(DEPTH);
    end

    // Bank flags, lengths and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full    <= '0;
            bank_len[0]  <= '0;
            bank_len[1]  <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (fill_accept) begin
                bank_full[fill_bank] <= 1'b1;
                bank_len[fill_bank]  <= fill_len_c;
            end
            if (fill_valid && (bank_full[fill_bank] || fill_over)) begin
                overflow_err <= 1'b1;
            end
            // A releasing bank is still full here, so a same-cycle fill is rejected above.
            if (state == S_RELEASE) begin
                bank_full[next_bank] <= 1'b0;
            end
        end
    end

    // Control FSM with registered read and release outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            next_bank     <= 1'b0;
            rd_en         <= 1'b0;
            rd_bank       <= 1'b0;
            rd_addr       <= '0;
            release_valid <= 1'b0;
            release_bank  <= 1'b0;
        end else begin
            release_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cur_full) begin
                        if (cur_len == '0) begin
                            state         <= S_RELEASE;
                            release_valid <= 1'b1;
                            release_bank  <= next_bank;
                        end else begin
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_bank <= next_bank;
                            rd_addr <= '0;
                        end
                    end
                end
                S_READ: begin
                    if (rd_en && last_addr_hit) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        if (rd_en) begin
                            rd_addr <= rd_addr + AWIDTH'(1);
                        end
                        rd_en <= credit_ok;
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state         <= S_RELEASE;
                        release_valid <= 1'b1;
                        release_bank  <= next_bank;
                    end
                end
                S_RELEASE: begin
                    next_bank <= ~next_bank;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-return pipeline and output FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_en;
            pipe_last[0] <= rd_en && last_addr_hit;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
        end
    end

`ifdef DBR_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dbram_bank_reader.sv
// tb/tb_dbram_bank_reader.sv - directed self-checking bench for dbram_bank_reader

module tb_dbram_bank_reader;

    localparam int AW = 12;
    localparam int DW = 60;

    logic          clk;
    logic          reset;

    // Instance A: RD_LATENCY = 1
    logic          fill_valid;
    logic          fill_bank;
    logic [AW:0]   fill_len;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          release_valid;
    logic          release_bank;
    logic          overflow_err;
`ifdef DBR_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   b_stall_cnt;
`endif

    // Instance B: RD_LATENCY = 3
    logic          b_fill_valid;
    logic          b_fill_bank;
    logic [AW:0]   b_fill_len;
    logic          b_rd_en;
    logic          b_rd_bank;
    logic [AW-1:0] b_rd_addr;
    logic [DW-1:0] b_rd_data;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [DW-1:0] b_out_data;
    logic          b_out_last;
    logic          b_release_valid;
    logic          b_release_bank;
    logic          b_overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    dbram_bank_reader #(.AWIDTH(AW), .NUM_WORDS(4096), .DWIDTH(DW), .RD_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .fill_valid(fill_valid), .fill_bank(fill_bank), .fill_len(fill_len),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .release_valid(release_valid), .release_bank(release_bank), .overflow_err(overflow_err)
`ifdef DBR_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    dbram_bank_reader #(.AWIDTH(AW), .NUM_WORDS(4096), .DWIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .fill_valid(b_fill_valid), .fill_bank(b_fill_bank), .fill_len(b_fill_len),
        .rd_en(b_rd_en), .rd_bank(b_rd_bank), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .release_valid(b_release_valid), .release_bank(b_release_bank), .overflow_err(b_overflow_err)
`ifdef DBR_STALL_CNT_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: word content = {bank, addr}
    always @(posedge clk) begin
        if (rd_en) rd_data <= {47'b0, rd_bank, rd_addr};
    end

    logic [DW-1:0] b_s1, b_s2;
    always @(posedge clk) begin
        if (b_rd_en) b_s1 <= {47'b0, b_rd_bank, b_rd_addr};
        b_s2      <= b_s1;
        b_rd_data <= b_s2;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        fill_valid   = 1'b0;
        b_fill_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fill_a(input logic bank, input int len);
        fill_valid = 1'b1;
        fill_bank  = bank;
        fill_len   = (AW+1)'(len);
        step();
        fill_valid = 1'b0;
    endtask

    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    bit            q_rel[$];
    int            max_addr;
    bit            bad_order;

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_rel.delete();
        max_addr  = 0;
        bad_order = 0;
    endtask

    task automatic collect_a(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (release_valid) q_rel.push_back(release_bank);
            if (rd_en && rd_bank && (q_rel.size() == 0)) bad_order = 1;
            if (rd_en && (int'(rd_addr) > max_addr)) max_addr = int'(rd_addr);
            step();
        end
    endtask

    function automatic logic [63:0] get_d(input int i);
        return (i < q_data.size()) ? 64'(q_data[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] get_l(input int i);
        return (i < q_last.size()) ? 64'(q_last[i]) : 64'hFF;
    endfunction

    function automatic logic [63:0] get_r(input int i);
        return (i < q_rel.size()) ? 64'(q_rel[i]) : 64'hFF;
    endfunction

    initial begin
        int issued, popped, maxdiff, stable_bad, order_bad, nlast, rel_cnt;
        bit prev_stall, prev_last, seen_rel, seen_out;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] b_words[$];

        reset = 1'b1;
        fill_valid = 0; fill_bank = 0; fill_len = '0; out_ready = 1'b1;
        b_fill_valid = 0; b_fill_bank = 0; b_fill_len = '0; b_out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_release", release_valid, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_data", out_data, 0);

        // Single bank, len 8, exact timing
        fill_a(0, 8);                                   // now cycle 1
        check("t1_rd_en_c1", rd_en, 1);
        check("t1_rd_addr_c1", rd_addr, 0);
        check("t1_rd_bank_c1", rd_bank, 0);
        check("t1_out_valid_c1", out_valid, 0);
        step();                                         // cycle 2
        check("t1_out_valid_c2", out_valid, 0);
        step();                                         // cycle 3
        for (int k = 0; k < 8; k++) begin
            check("t1_out_valid", out_valid, 1);
            check("t1_out_data", out_data, k);
            check("t1_out_last", out_last, (k == 7));
            step();
        end
        check("t1_release", release_valid, 1);
        check("t1_release_bank", release_bank, 0);
        check("t1_out_valid_end", out_valid, 0);
        step();
        check("t1_release_pulse", release_valid, 0);

        // Back-to-back banks 0 (len 4) and 1 (len 3)
        do_reset();
        clear_q();
        fill_a(0, 4);
        fill_a(1, 3);
        collect_a(40);
        check("t2_count", q_data.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check("t2_data", get_d(i), (i < 4) ? i : (64'h1000 + 64'(i - 4)));
            check("t2_last", get_l(i), (i == 3 || i == 6));
        end
        check("t2_rel_count", q_rel.size(), 2);
        check("t2_rel0", get_r(0), 0);
        check("t2_rel1", get_r(1), 1);
        check("t2_order", bad_order, 0);

        // RD_LATENCY=3 instance, out_ready toggling, len 16
        do_reset();
        b_fill_valid = 1'b1; b_fill_bank = 1'b0; b_fill_len = 13'd16;
        step();
        b_fill_valid = 1'b0;
        issued = 0; popped = 0; maxdiff = 0; stable_bad = 0; rel_cnt = 0;
        prev_stall = 0; prev_last = 0; prev_data = '0;
        for (int c = 0; c < 200; c++) begin
            b_out_ready = (c % 2 == 0);
            issued += int'(b_rd_en);
            if (issued - popped > maxdiff) maxdiff = issued - popped;
            if (prev_stall && (!b_out_valid || b_out_data !== prev_data || b_out_last !== prev_last))
                stable_bad++;
            if (b_out_valid && b_out_ready) begin
                b_words.push_back(b_out_data);
                if (b_out_last && b_words.size() != 16) stable_bad++;
                popped++;
            end
            if (b_release_valid && !b_release_bank) rel_cnt++;
            prev_stall = b_out_valid && !b_out_ready;
            prev_data  = b_out_data;
            prev_last  = b_out_last;
            step();
        end
        b_out_ready = 1'b1;
        order_bad = 0;
        for (int i = 0; i < b_words.size(); i++) if (b_words[i] != DW'(i)) order_bad++;
        check("t3_count", b_words.size(), 16);
        check("t3_order", order_bad, 0);
        check("t3_stable", stable_bad, 0);
        check("t3_credit_le5", (maxdiff <= 5), 1);
        check("t3_release", rel_cnt, 1);

        // Zero-length bank
        do_reset();
        fill_a(0, 0);
        seen_rel = 0; seen_out = 0;
        for (int c = 0; c < 3; c++) begin
            if (release_valid && !release_bank) seen_rel = 1;
            if (out_valid) seen_out = 1;
            step();
        end
        check("t4_release", seen_rel, 1);
        check("t4_no_out", seen_out, 0);
        check("t4_no_ovf", overflow_err, 0);

        // Refill of a full bank
        do_reset();
        fill_a(1, 5);
        check("t5_ovf_before", overflow_err, 0);
        fill_a(1, 9);
        check("t5_ovf_set", overflow_err, 1);
        clear_q();
        fill_a(0, 2);
        collect_a(40);
        check("t5_count", q_data.size(), 7);
        check("t5_b0_w1", get_d(1), 1);
        check("t5_b1_w0", get_d(2), 64'h1000);
        check("t5_b1_w4", get_d(6), 64'h1004);
        check("t5_b1_last", get_l(6), 1);
        check("t5_rel_count", q_rel.size(), 2);
        check("t5_ovf_sticky", overflow_err, 1);

        // Reset in the middle of a 4096-word bank
        do_reset();
        fill_a(0, 4096);
        repeat (20) step();
        check("t6_rd_en_mid", rd_en, 1);
        check("t6_out_valid_mid", out_valid, 1);
        reset = 1'b1;
        step();
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_rst_rd_addr", rd_addr, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        check("t6_rst_out_last", out_last, 0);
        check("t6_rst_release", release_valid, 0);
        reset = 1'b0;
        clear_q();
        fill_a(0, 2);
        collect_a(20);
        check("t6_count", q_data.size(), 2);
        check("t6_w0", get_d(0), 0);
        check("t6_w1", get_d(1), 1);
        check("t6_last", get_l(1), 1);
        check("t6_rel", q_rel.size(), 1);

        // fill_len above NUM_WORDS clamps to a full 4096-word bank
        do_reset();
        clear_q();
        fill_a(0, 4097);
        check("t7_ovf", overflow_err, 1);
        collect_a(4120);
        order_bad = 0; nlast = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] != DW'(i)) order_bad++;
            if (q_last[i]) nlast++;
        end
        check("t7_count", q_data.size(), 4096);
        check("t7_order", order_bad, 0);
        check("t7_last_count", nlast, 1);
        check("t7_last_pos", get_l(4095), 1);
        check("t7_max_addr", max_addr, 4095);
        check("t7_rel", q_rel.size(), 1);

`ifdef DBR_STALL_CNT_EN
        do_reset();
        out_ready = 1'b0;
        fill_a(0, 2);
        for (int c = 0; c < 10 && !out_valid; c++) step();
        check("t8_out_valid", out_valid, 1);
        check("t8_stall_start", stall_cnt, 0);
        repeat (10) step();
        check("t8_stall_cnt", stall_cnt, 10);
        out_ready = 1'b1;
        repeat (6) step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
